// File: rtl/mesi_isc_arb_pkg.sv
// Shared types and helpers for the breq-to-broad weighted round-robin arbiter.
package mesi_isc_arb_pkg;

    localparam int unsigned N_PORTS = 4;

    typedef logic [3:0] port_oh_t;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_STARVE = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_NEW    = 2'd3
    } sel_mode_e;

    function automatic port_oh_t rotl1(input port_oh_t x);
        return {x[2:0], x[3]};
    endfunction

    // Input is one-hot or zero; zero maps to index 0.
    function automatic logic [1:0] oh2bin(input port_oh_t x);
        logic [1:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) b = b | 2'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/mesi_isc_rr_pick.sv
// Circular first-set picker: grants the first request at or after the one-hot pointer.
module mesi_isc_rr_pick
    import mesi_isc_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] ptr,
    output logic [3:0] gnt
);

    logic [1:0] base;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        base  = oh2bin(ptr);
        for (int off = 0; off < 4; off++) begin
            idx = base + 2'(off);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_breq_wrr_arb.sv
// Weighted round-robin arbiter with age-based starvation forcing that shares the
// broad FIFO write port between the four per-CPU breq FIFOs.
module mesi_isc_breq_wrr_arb
    import mesi_isc_arb_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = 3,
    parameter int unsigned AGE_WIDTH    = 4,
    parameter int unsigned AGE_LIMIT    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                fifo_status_empty_array_i,
    input  logic                      broad_fifo_status_full_i,
    input  logic [4*WEIGHT_WIDTH-1:0] weight_array_i,
    output logic [3:0]                fifo_rd_array_o,
    output logic                      broad_fifo_wr_o,
    output logic [3:0]                fifo_select_oh_o,
    output logic [1:0]                broad_cpu_id_o,
    output logic [3:0]                starve_array_o
);

    localparam logic [AGE_WIDTH-1:0]    AGE_MAX = AGE_WIDTH'(AGE_LIMIT);
    localparam logic [WEIGHT_WIDTH-1:0] W_ONE   = WEIGHT_WIDTH'(1);

    port_oh_t              owner_q, owner_d;
    port_oh_t              rr_ptr_q, rr_ptr_d;
    port_oh_t              starve_q, starve_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [AGE_WIDTH-1:0]  age_q [4];
    logic [AGE_WIDTH-1:0]  age_d [4];

    port_oh_t              elig;
    port_oh_t              starve_req;
    port_oh_t              starve_gnt;
    port_oh_t              elig_gnt;
    port_oh_t              sel;
    sel_mode_e             mode;
    logic [WEIGHT_WIDTH-1:0] w_sel;
    logic [WEIGHT_WIDTH-1:0] w_eff;
    logic                  xfer;

    assign elig       = ~fifo_status_empty_array_i;
    assign starve_req = starve_q & elig;

    mesi_isc_rr_pick u_pick_starve (
        .req (starve_req),
        .ptr (rr_ptr_q),
        .gnt (starve_gnt)
    );

    mesi_isc_rr_pick u_pick_elig (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (elig_gnt)
    );

    // Priority: starved FIFO, then continuing burst, then plain round robin.
    always_comb begin
        mode = MODE_NONE;
        sel  = '0;
        if (|starve_req) begin
            mode = MODE_STARVE;
            sel  = starve_gnt;
        end else if ((|(owner_q & elig)) && (credit_q != '0)) begin
            mode = MODE_BURST;
            sel  = owner_q;
        end else if (|elig) begin
            mode = MODE_NEW;
            sel  = elig_gnt;
        end
        w_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) w_sel = weight_array_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        w_eff = (w_sel == '0) ? W_ONE : w_sel;
    end

    assign xfer = ~rst & ~broad_fifo_status_full_i & (|sel);

    // Next-state: burst bookkeeping and ages only move on an actual transfer.
    always_comb begin
        owner_d  = owner_q;
        credit_d = credit_q;
        rr_ptr_d = rr_ptr_q;
        age_d    = age_q;
        if (xfer) begin
            case (mode)
                MODE_STARVE: begin
                    owner_d  = '0;
                    credit_d = '0;
                    rr_ptr_d = rotl1(sel);
                end
                MODE_BURST: begin
                    credit_d = credit_q - W_ONE;
                    if (credit_q == W_ONE) begin
                        owner_d  = '0;
                        rr_ptr_d = rotl1(sel);
                    end
                end
                MODE_NEW: begin
                    if (w_eff == W_ONE) begin
                        owner_d  = '0;
                        credit_d = '0;
                        rr_ptr_d = rotl1(sel);
                    end else begin
                        owner_d  = sel;
                        credit_d = w_eff - W_ONE;
                    end
                end
                default: ;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (sel[i] || !elig[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + AGE_WIDTH'(1);
                end
            end
        end
        starve_d = '0;
        for (int i = 0; i < 4; i++) begin
            starve_d[i] = (age_d[i] == AGE_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= '0;
            credit_q <= '0;
            rr_ptr_q <= 4'b0001;
            starve_q <= '0;
            for (int i = 0; i < 4; i++) age_q[i] <= '0;
        end else begin
            owner_q  <= owner_d;
            credit_q <= credit_d;
            rr_ptr_q <= rr_ptr_d;
            starve_q <= starve_d;
            age_q    <= age_d;
        end
    end

    // Zero-latency outputs, forced quiet while reset is held.
    always_comb begin
        fifo_select_oh_o = rst ? 4'b0000 : sel;
        fifo_rd_array_o  = fifo_select_oh_o & {4{~broad_fifo_status_full_i}};
        broad_fifo_wr_o  = |fifo_rd_array_o;
        broad_cpu_id_o   = oh2bin(fifo_select_oh_o);
        starve_array_o   = starve_q;
    end

endmodule

// File: doc/mesi_isc_breq_wrr_arb.md
Name: mesi_isc_breq_wrr_arb

Overview:
- Weighted round-robin arbiter with starvation protection that shares the single broadcast FIFO write port between the four per-CPU breq FIFOs.
- It picks which non-empty breq FIFO is read into the broad FIFO each cycle and drives the one-hot select for the breq-to-broad mux.
- It lets a configured CPU drain bursts of up to WEIGHT consecutive breqs, but bounds how long any other non-empty FIFO waits.
- It sits between the breq FIFO status/read ports and the broad FIFO write port.

Parameters:
- WEIGHT_WIDTH, 3, width of each per-FIFO burst weight; maximum burst is 2^WEIGHT_WIDTH-1.
- AGE_WIDTH, 4, width of each per-FIFO age (lost-grant) counter.
- AGE_LIMIT, 12, age value at which a FIFO is starved and forced; must be between 1 and 2^AGE_WIDTH-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- fifo_status_empty_array_i  in  4  per-breq-FIFO empty flag; bit n is CPU n
- broad_fifo_status_full_i  in  1  broad FIFO full
- weight_array_i  in  4*WEIGHT_WIDTH  per-FIFO burst weight; field n is bits [(n+1)*WEIGHT_WIDTH-1 : n*WEIGHT_WIDTH]; quasi-static
- fifo_rd_array_o  out  4  one-hot breq FIFO read strobe
- broad_fifo_wr_o  out  1  broad FIFO write, equal to the OR of fifo_rd_array_o
- fifo_select_oh_o  out  4  one-hot mux select; zero when no FIFO is eligible
- broad_cpu_id_o  out  2  binary index of fifo_select_oh_o; 0 when the select is zero
- starve_array_o  out  4  registered; bit n is 1 when age[n]==AGE_LIMIT

Behaviour:
- State:
  - owner: 4-bit one-hot or zero.
  - credit: WEIGHT_WIDTH bits.
  - rr_ptr: 4-bit one-hot.
  - age[0..3]: AGE_WIDTH bits each.
- Reset values: owner=0, credit=0, rr_ptr=4'b0001, all age=0, starve_array_o=0.
  - While rst=1, fifo_rd_array_o, broad_fifo_wr_o, fifo_select_oh_o and broad_cpu_id_o are forced to 0, gated combinationally.
  - Asserting rst mid-burst abandons the burst; no partial state survives.
- Eligibility: elig = ~fifo_status_empty_array_i.
- Selection is combinational, zero latency, evaluated in this order:
  1. If (starve & elig) is non-zero, select the first set bit of it in circular order starting at rr_ptr.
  2. Else if (owner & elig) is non-zero and credit != 0, select owner (burst continues).
  3. Else select the first bit of elig in circular order starting at rr_ptr.
  4. Else select 0.
- Transfer: fifo_rd_array_o = fifo_select_oh_o & {4{~broad_fifo_status_full_i}}.
  - broad_fifo_wr_o is asserted in the same cycle as the read.
- On a transfer from FIFO p, with W = weight[p] and W==0 treated as 1:
  - Case 2 (burst continues): credit <= credit-1. If credit-1 == 0, then owner <= 0 and rr_ptr <= rotl1(one-hot p).
  - Case 3 (new burst): if W == 1, then owner <= 0, credit <= 0 and rr_ptr <= rotl1(p). Otherwise owner <= p and credit <= W-1.
  - Case 1 (starvation force): owner <= 0, credit <= 0, rr_ptr <= rotl1(p). Any preempted burst is abandoned.
- Age updates happen only in cycles with a transfer:
  - The granted FIFO's age goes to 0.
  - Every other eligible FIFO's age is incremented, saturating at AGE_LIMIT.
  - Non-eligible FIFOs' ages go to 0.
  - In cycles with no transfer, all ages hold. A broad-full stall therefore never creates starvation.
- Stall: while broad full, there are no reads, and owner, credit, rr_ptr and ages all hold. fifo_select_oh_o still shows the pending choice.
- Owner goes empty mid-burst: case 2 no longer applies and case 3 picks the next FIFO from rr_ptr.
  - rr_ptr is unchanged by the owner emptying; a new burst overwrites owner and credit.
- Weight changes take effect only at the next new-burst load.
- Invariant: fifo_rd_array_o and fifo_select_oh_o are always one-hot or zero.

Decomposition:
- Package mesi_isc_arb_pkg contains:
  - typedef logic [3:0] port_oh_t
  - function rotl1(port_oh_t), implementing {x[2:0], x[3]}
  - function oh2bin(port_oh_t), returning 2 bits
- Sub-module mesi_isc_rr_pick (combinational):
  - inputs req[3:0] and ptr[3:0] (one-hot); output gnt[3:0], one-hot, the first req at or after ptr in circular order.
  - Instantiated twice: once for the starved set and once for elig.

Test Plan:
1. Default round robin: weights all 1, all FIFOs non-empty, broad never full → reads 0,1,2,3,0,1 on consecutive cycles; broad_cpu_id_o follows 0,1,2,3.
2. Weighted bursts: weights {w3,w2,w1,w0} = {1,1,2,3}, all non-empty → read order 0,0,0,1,1,2,3,0,0,0.
3. Starvation: AGE_LIMIT=4, w0=7, only FIFOs 0 and 1 non-empty → reads 0,0,0,0 and starve_array_o[1] rises after the 4th.
   - Next read is 1 (forced), then a fresh burst from 0 with credit 6.
   - age[1] returns to 0.
4. Full stall: start a burst of 0 with w0=3 after 1 read, then hold broad full 5 cycles → no reads, ages unchanged; on release 0 is read twice more, then 1.
5. Weight 0 and empty: w2=0, only FIFO 2 non-empty → one read per cycle, owner stays 0, rr_ptr=4'b1000 after each read.
   - All FIFOs empty → select 0, broad_cpu_id_o 0, no writes.
6. Reset mid-burst: assert rst during w0=3 burst after first read → outputs go to 0 immediately.
   - After release, selection restarts from rr_ptr=0001 with credit cleared.
